mlp_layer_scheduler: RTL and testbench

Sequences one MLP layer over a shared single-neuron datapath with ping-pong weight SRAMs. While neuron n computes from one bank, the weights for neuron n+1 load into the other bank. The block generates all SRAM write/read strobes, accumulator controls and the result handshake. It sits between the host weight/input streams and the neuron datapath (SRAM pair, input mux, MAC register, activation).

---
 rtl/mlp_layer_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mlp_layer_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_scheduler.sv
// Layer sequencer for a shared single-neuron datapath with ping-pong weight banks.
// Optional stall counter enabled by defining MLP_LAYER_SCHED_STALL_CNT_EN.
module mlp_layer_scheduler #(
  parameter int ADDR_W  = 3,
  parameter int NEURONS = 4,
  parameter int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              act_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  neuron_idx,
  output logic              busy,
  output logic              done
`ifdef MLP_LAYER_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int LD_W = $clog2(NEURONS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT_BANK, MAC, FLUSH1, FLUSH2, OUTPUT
  } state_t;

  state_t          state;
  logic [1:0]      full;
  logic [LD_W-1:0] loaded;
  logic            start_acc;
  logic            wr_done;
  logic            rd_release;

  assign start_acc  = start & (state == IDLE);
  assign w_ready    = busy & ~full[wr_bank] & (loaded < LD_W'(NEURONS));
  assign wr_en      = w_valid & w_ready;
  assign wr_done    = wr_en & (wr_addr == LAST_ADDR);
  assign x_ready    = (state == MAC);
  assign rd_en      = x_valid & x_ready;
  assign acc_clear  = (state == WAIT_BANK) & full[rd_bank];
  assign rd_release = (state == OUTPUT) & out_ready;

  // Write side streams weights into whichever bank is free, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      loaded  <= '0;
    end else if (start_acc) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      loaded  <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + 1'b1;
      if (wr_done) begin
        wr_bank <= ~wr_bank;
        loaded  <= loaded + 1'b1;
      end
    end
  end

  // Set and release always hit opposite banks, so both may land in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else if (start_acc) begin
      full <= 2'b00;
    end else begin
      if (wr_done)    full[wr_bank] <= 1'b1;
      if (rd_release) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      neuron_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      act_en     <= 1'b0;
      acc_en     <= 1'b0;
    end else begin
      acc_en <= rd_en;
      done   <= 1'b0;
      act_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            neuron_idx <= '0;
            state      <= WAIT_BANK;
          end
        end
        WAIT_BANK: begin
          if (full[rd_bank]) state <= MAC;
        end
        MAC: begin
          if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == LAST_ADDR) state <= FLUSH1;
          end
        end
        FLUSH1: begin
          act_en <= 1'b1;
          state  <= FLUSH2;
        end
        FLUSH2: begin
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rd_bank   <= ~rd_bank;
            if (neuron_idx == IDX_W'(NEURONS - 1)) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              neuron_idx <= '0;
              state      <= IDLE;
            end else begin
              neuron_idx <= neuron_idx + 1'b1;
              state      <= WAIT_BANK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MLP_LAYER_SCHED_STALL_CNT_EN
  logic stall_now;
  assign stall_now = ((state == WAIT_BANK) & ~full[rd_bank]) |
                     ((state == MAC) & ~x_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'h0000;
    end else if (start_acc) begin
      stall_cycles <= 16'h0000;
    end else if (stall_now && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Directed bench for mlp_layer_scheduler at ADDR_W=2, NEURONS=3.
module tb_mlp_layer_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       w_valid;
  logic       w_ready;
  logic       x_valid;
  logic       x_ready;
  logic       wr_en;
  logic       wr_bank;
  logic [1:0] wr_addr;
  logic       rd_en;
  logic       rd_bank;
  logic [1:0] rd_addr;
  logic       acc_clear;
  logic       acc_en;
  logic       act_en;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] neuron_idx;
  logic       busy;
  logic       done;
`ifdef MLP_LAYER_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  mlp_layer_scheduler #(.ADDR_W(2), .NEURONS(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_valid(w_valid), .w_ready(w_ready),
    .x_valid(x_valid), .x_ready(x_ready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .acc_clear(acc_clear), .acc_en(acc_en), .act_en(act_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .neuron_idx(neuron_idx), .busy(busy), .done(done)
`ifdef MLP_LAYER_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int wr_cyc[$];
  int wr_tag[$];
  int clr_cyc[$];
  int act_cyc[$];
  int acc_cyc[$];
  int acc_idx[$];
  int done_cyc[$];
  int first_xr;
  int n_rd;
  int n_acc;
  int lag_err;
  logic prev_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    cyc = -1;
    wr_cyc.delete(); wr_tag.delete(); clr_cyc.delete(); act_cyc.delete();
    acc_cyc.delete(); acc_idx.delete(); done_cyc.delete();
    first_xr = -1; n_rd = 0; n_acc = 0; lag_err = 0; prev_rd = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step(input logic s, input logic wv, input logic xv, input logic ordy);
    @(negedge clk);
    start = s; w_valid = wv; x_valid = xv; out_ready = ordy;
    #1;
    cyc++;
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_tag.push_back(int'({wr_bank, wr_addr}));
    end
    if (acc_clear) clr_cyc.push_back(cyc);
    if (act_en) act_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      acc_idx.push_back(int'(neuron_idx));
    end
    if (done) done_cyc.push_back(cyc);
    if (x_ready && first_xr < 0) first_xr = cyc;
    if (rd_en) n_rd++;
    if (acc_en) n_acc++;
    if (acc_en != prev_rd) lag_err++;
    prev_rd = rd_en;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, out_valid, acc_en, act_en, done, acc_clear,
                            wr_en, rd_en, wr_bank, rd_bank, w_ready, x_ready}), 32'd0);
    chk({tag, "_addr"}, 32'({wr_addr, rd_addr, neuron_idx}), 32'd0);
  endtask

  int hold_ok;
  int w_stall;
  int k;

  initial begin
    reset = 1'b1; start = 1'b0; w_valid = 1'b0; x_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Inputs waiting before weights, then 5 cycles of result backpressure.
    clear_log();
    hold_ok = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 10; i <= 27; i++) begin
      step(1'b0, 1'b1, 1'b1, (i == 26));
      if (cyc >= 21 && cyc <= 25 && out_valid && !rd_bank && !w_ready) hold_ok++;
    end
    chk("wr4_cyc", (wr_cyc.size() > 3) ? wr_cyc[3] : -1, 13);
    chk("first_clr", (clr_cyc.size() > 0) ? clr_cyc[0] : -1, 14);
    chk("first_xready", first_xr, 15);
    chk("act_cyc", (act_cyc.size() > 0) ? act_cyc[0] : -1, 20);
    chk("hold_cycles", hold_ok, 5);
    chk("accept_cyc", (acc_cyc.size() > 0) ? acc_cyc[0] : -1, 26);
    chk("rd_bank_after", 32'(rd_bank), 1);
    chk("clr_after", 32'(acc_clear), 1);
    chk("w_ready_after", 32'(w_ready), 1);

    // Abort in the middle of neuron 1's MAC.
    k = 0;
    while (!(x_ready && rd_addr == 2'd2) && k < 20) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      k++;
    end
    chk("mac_rd2_cyc", cyc, 30);
    #1 reset = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;

    // Full layer with continuous streams and no backpressure.
    clear_log();
    w_stall = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    while (done_cyc.size() == 0 && cyc < 60) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (cyc >= 9 && cyc <= 12 && w_ready) w_stall++;
    end
    chk("wr_count", wr_cyc.size(), 12);
    for (int i = 0; i < 12 && i < wr_tag.size(); i++)
      chk($sformatf("wr_tag%0d", i), wr_tag[i], ((i / 4) % 2) * 4 + (i % 4));
    chk("wr_first_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 1);
    chk("wr_resume_cyc", (wr_cyc.size() > 8) ? wr_cyc[8] : -1, 13);
    chk("w_both_full", w_stall, 0);
    chk("accept_count", acc_cyc.size(), 3);
    for (int i = 0; i < 3 && i < acc_cyc.size(); i++) begin
      chk($sformatf("accept%0d_cyc", i), acc_cyc[i], 12 + 8 * i);
      chk($sformatf("accept%0d_idx", i), acc_idx[i], i);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("clr%0d_cyc", i), (clr_cyc.size() > i) ? clr_cyc[i] : -1, 5 + 8 * i);
      chk($sformatf("act%0d_cyc", i), (act_cyc.size() > i) ? act_cyc[i] : -1, 11 + 8 * i);
    end
    chk("done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 29);
    chk("busy_at_done", 32'(busy), 0);
    chk("idx_at_done", 32'(neuron_idx), 0);
    chk("rd_count", n_rd, 12);
    chk("acc_count", n_acc, 12);
    chk("acc_en_lag", lag_err, 0);

`ifdef MLP_LAYER_SCHED_STALL_CNT_EN
    clear_log();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("stall_wait", 32'(stall_cycles), 4);
    for (int i = 6; i <= 13; i++) step(1'b0, 1'b1, !(i >= 7 && i <= 9), 1'b1);
    chk("stall_mac", 32'(stall_cycles), 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
